// File: rtl/frac_search_ctrl.sv
// Quarter-pel refinement sequencer: fetches 9 candidates x HEIGHT rows, keeps min-SAD winner.
// Optional FRAC_SEARCH_EARLY_TERM_EN: abandon a candidate once its partial SAD cannot win.
module frac_search_ctrl #(
    parameter int HEIGHT    = 8,
    parameter int ROW_SAD_W = 11,
    parameter int ACC_W     = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 rd_req,
    output logic [3:0]           rd_cand,
    output logic [2:0]           rd_row,
    input  logic                 rd_valid,
    input  logic [ROW_SAD_W-1:0] row_sad,
    output logic                 done,
    output logic [2:0]           best_mvx,
    output logic [2:0]           best_mvy,
    output logic [ACC_W-1:0]     best_sad
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EVAL,
        DONE
    } state_t;

    localparam logic [2:0] LAST_ROW  = 3'(HEIGHT - 1);
    localparam logic [3:0] LAST_CAND = 4'd8;

    state_t             state_q, state_d;
    logic [3:0]         cand_q, cand_d;
    logic [2:0]         row_q, row_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [2:0]         mvx_q, mvx_d;
    logic [2:0]         mvy_q, mvy_d;
    logic [ACC_W-1:0]   bsad_q, bsad_d;
    logic [ACC_W-1:0]   acc_sum;
    logic               early;
    logic [2:0]         cmvx, cmvy;

    assign acc_sum = acc_q + ACC_W'(row_sad);

`ifdef FRAC_SEARCH_EARLY_TERM_EN
    assign early = (cand_q != 4'd0) && (acc_sum >= bsad_q);
`else
    assign early = 1'b0;
`endif

    // Candidate index to (mvx, mvy): x = c mod 3 - 1, y = c div 3 - 1
    always_comb begin
        cmvx = 3'b000;
        cmvy = 3'b000;
        unique case (cand_q)
            4'd0: begin cmvx = 3'b111; cmvy = 3'b111; end
            4'd1: begin cmvx = 3'b000; cmvy = 3'b111; end
            4'd2: begin cmvx = 3'b001; cmvy = 3'b111; end
            4'd3: begin cmvx = 3'b111; cmvy = 3'b000; end
            4'd4: begin cmvx = 3'b000; cmvy = 3'b000; end
            4'd5: begin cmvx = 3'b001; cmvy = 3'b000; end
            4'd6: begin cmvx = 3'b111; cmvy = 3'b001; end
            4'd7: begin cmvx = 3'b000; cmvy = 3'b001; end
            4'd8: begin cmvx = 3'b001; cmvy = 3'b001; end
            default: begin cmvx = 3'b000; cmvy = 3'b000; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        row_d   = row_q;
        acc_d   = acc_q;
        mvx_d   = mvx_q;
        mvy_d   = mvy_q;
        bsad_d  = bsad_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cand_d  = 4'd0;
                    row_d   = 3'd0;
                    acc_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (rd_valid) begin
                    acc_d = acc_sum;
                    if (row_q == LAST_ROW || early) begin
                        state_d = EVAL;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end
            end
            EVAL: begin
                // Strict compare: ties keep the earlier candidate
                if (cand_q == 4'd0 || acc_q < bsad_q) begin
                    bsad_d = acc_q;
                    mvx_d  = cmvx;
                    mvy_d  = cmvy;
                end
                if (cand_q == LAST_CAND) begin
                    state_d = DONE;
                end else begin
                    cand_d  = cand_q + 4'd1;
                    row_d   = 3'd0;
                    acc_d   = '0;
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= 4'd0;
            row_q   <= 3'd0;
            acc_q   <= '0;
            mvx_q   <= 3'd0;
            mvy_q   <= 3'd0;
            bsad_q  <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            mvx_q   <= mvx_d;
            mvy_q   <= mvy_d;
            bsad_q  <= bsad_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign rd_req   = (state_q == FETCH);
    assign rd_cand  = cand_q;
    assign rd_row   = row_q;
    assign done     = (state_q == DONE);
    assign best_mvx = mvx_q;
    assign best_mvy = mvy_q;
    assign best_sad = bsad_q;

endmodule

// File: tb/tb_frac_search_ctrl.sv
// Directed bench for frac_search_ctrl: ordering, stalls, ignored inputs, reset abort.
module tb_frac_search_ctrl;

`ifdef FRAC_SEARCH_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        rd_req;
    logic [3:0]  rd_cand;
    logic [2:0]  rd_row;
    logic        rd_valid = 1'b0;
    logic [10:0] row_sad;
    logic        done;
    logic [2:0]  best_mvx;
    logic [2:0]  best_mvy;
    logic [13:0] best_sad;

    logic [10:0] sad_tab [16];
    int n_cmp = 0;
    int n_err = 0;

    assign row_sad = sad_tab[rd_cand];

    always #5 clk = ~clk;

    frac_search_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rd_req(rd_req), .rd_cand(rd_cand), .rd_row(rd_row),
        .rd_valid(rd_valid), .row_sad(row_sad), .done(done),
        .best_mvx(best_mvx), .best_mvy(best_mvy), .best_sad(best_sad)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input logic [10:0] base, input int idx,
                        input logic [10:0] val);
        for (int i = 0; i < 16; i++) sad_tab[i] = base;
        sad_tab[idx] = val;
    endtask

    // One full search; cyc counts negedges after the start edge (cycle k+cyc)
    task automatic run(input string tag, input bit stall, input bit noise,
                       input int exp_lat, input int exp_acc,
                       input logic [2:0] emx, input logic [2:0] emy,
                       input logic [13:0] esad);
        int cyc, stalls, acc_n, done_cyc, lc, lr;
        bit order_ok, stable_ok, pstall;
        logic [3:0] pc;
        logic [2:0] pr;
        stalls = 0; acc_n = 0; done_cyc = 0; lc = 0; lr = -1;
        order_ok = 1; stable_ok = 1; pstall = 0; pc = 0; pr = 0;
        @(negedge clk);
        start = 1'b1;
        rd_valid = 1'b0;
        for (cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk);
            start = noise && (cyc == 5);
            if (done) begin
                done_cyc = cyc;
                start = noise;
                rd_valid = noise;
                break;
            end
            if (rd_req) begin
                if (pstall && (rd_cand != pc || rd_row != pr)) stable_ok = 0;
                rd_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                pstall = !rd_valid;
                pc = rd_cand;
                pr = rd_row;
                if (rd_valid) begin
                    if (int'(rd_cand) == lc) begin
                        if (int'(rd_row) != lr + 1) order_ok = 0;
                    end else if (int'(rd_cand) != lc + 1 || rd_row != 0 ||
                                 (!ET && lr != 7)) begin
                        order_ok = 0;
                    end
                    lc = int'(rd_cand);
                    lr = int'(rd_row);
                    acc_n++;
                end else begin
                    stalls++;
                end
            end else begin
                pstall = 0;
                rd_valid = noise;
            end
        end
        check({tag, "_order"}, {31'd0, order_ok}, 32'd1);
        check({tag, "_lastcand"}, lc, 8);
        check({tag, "_stable"}, {31'd0, stable_ok}, 32'd1);
        check({tag, "_accepted"}, acc_n, exp_acc);
        check({tag, "_latency"}, done_cyc, exp_lat + stalls);
        check({tag, "_mvx"}, best_mvx, emx);
        check({tag, "_mvy"}, best_mvy, emy);
        check({tag, "_sad"}, best_sad, esad);
        @(negedge clk);
        check({tag, "_done_1cyc"}, done, 0);
        check({tag, "_busy_fall"}, busy, 0);
        start = 1'b0;
        @(negedge clk);
        rd_valid = 1'b0;
        check({tag, "_idle_hold"}, busy, 0);
        check({tag, "_hold_sad"}, best_sad, esad);
    endtask

    initial begin
        int dn;
        load(11'd10, 0, 11'd10);
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req", rd_req, 0);
        check("rst_sad", best_sad, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        load(11'd10, 0, 11'd10);
        run("tie", 0, 0, 82, 72, 3'b111, 3'b111, 14'd80);

        load(11'd50, 4, 11'd1);
        run("ctr", 0, 0, ET ? 54 : 82, ET ? 44 : 72, 3'b000, 3'b000, 14'd8);

        load(11'd30, 8, 11'd2);
        run("stall", 1, 0, 82, 72, 3'b001, 3'b001, 14'd16);

        load(11'd50, 4, 11'd1);
        run("noise", 0, 1, ET ? 54 : 82, ET ? 44 : 72, 3'b000, 3'b000, 14'd8);

        // Abort a search while candidate 5 is being fetched
        load(11'd10, 0, 11'd10);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd_valid = 1'b1;
        for (int i = 0; i < 200 && rd_cand != 4'd5; i++) @(negedge clk);
        check("pre_rst_cand", rd_cand, 5);
        reset = 1'b1;
        #1;
        check("rst_busy2", busy, 0);
        check("rst_req2", rd_req, 0);
        check("rst_cand2", rd_cand, 0);
        check("rst_row2", rd_row, 0);
        check("rst_mv2", {best_mvx, best_mvy}, 0);
        check("rst_sad2", best_sad, 0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) reset = 1'b0;
            if (i == 1) rd_valid = 1'b0;
            if (done) dn++;
        end
        check("rst_nodone", dn, 0);
        run("clean", 0, 0, 82, 72, 3'b111, 3'b111, 14'd80);

        load(11'd255, 0, 11'd1);
        run("early", 0, 0, ET ? 26 : 82, ET ? 16 : 72, 3'b111, 3'b111, 14'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frac_search_ctrl.md
# frac_search_ctrl

Sequencer for the fractional motion-vector refinement stage. For each of the 9 quarter-pel candidate positions around the integer best match, it requests the 8 rows of the 8x8 block from the pixel fetch/filter path. It accumulates the per-row SAD returned by the SAD datapath and keeps the minimum-SAD candidate. At the end it reports the winning (mvx, mvy) and its SAD.

## Interface
Parameters:
- HEIGHT, 8: rows per block; also the row count per candidate.
- ROW_SAD_W, 11: width of per-row SAD input (8 × 255 fits 11 bits).
- ACC_W, 14: width of the candidate SAD accumulator and best_sad.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  begin a search; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- rd_req  out  1  row request; held high until accepted.
- rd_cand  out  4  candidate index 0..8 of the requested row.
- rd_row  out  3  row index 0..HEIGHT-1 of the requested row.
- rd_valid  in  1  row SAD valid; accepted only while rd_req=1.
- row_sad  in  ROW_SAD_W  SAD of the requested row.
- done  out  1  one-cycle pulse when results are final.
- best_mvx  out  3  signed quarter-pel x offset of winner, −1..+1.
- best_mvy  out  3  signed quarter-pel y offset of winner, −1..+1.
- best_sad  out  ACC_W  accumulated SAD of winner.

## Operation
- Candidate c maps to mvx = (c mod 3) − 1 and mvy = (c div 3) − 1, in two's complement. Scan order is c = 0..8, so the center (0,0) is c=4.
- FSM states are IDLE, FETCH, EVAL and DONE.
  - IDLE: busy=0, rd_req=0. When start=1: cand←0, row←0, acc←0, go to FETCH.
  - FETCH: rd_req=1, rd_cand=cand, rd_row=row. On rd_valid: acc←acc+row_sad. If row=HEIGHT−1, go to EVAL; otherwise row←row+1. Without rd_valid, hold state with all request outputs stable.
  - EVAL: rd_req=0. If cand=0 or acc<best_sad (strict), update best_sad←acc, best_mvx and best_mvy from cand. On ties the earlier candidate wins. Then:
    - if cand=8, go to DONE;
    - otherwise cand←cand+1, row←0, acc←0, go to FETCH.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- best_* registers hold their values from DONE until the next search updates them in its first EVAL.
- start while busy=1 is ignored, including a start pulse in the DONE cycle.
- rd_valid while rd_req=0 is ignored.
- The accumulator does not saturate: HEIGHT × (2^ROW_SAD_W − 1) must fit ACC_W. With the defaults this fits exactly.

## Timing
- rd_valid may be asserted combinationally in the same cycle rd_req rises. The row is accepted on that clock edge.
- With rd_valid held at 1, each candidate takes HEIGHT FETCH cycles plus 1 EVAL cycle, i.e. 9 cycles.
- If start is sampled at edge k, FETCH begins at cycle k+1 and done is high in cycle k+1+9×9 = k+82. busy falls in cycle k+83.
- Each stall cycle (rd_req=1, rd_valid=0) adds exactly one cycle.
- Reset, including mid-search: state=IDLE, cand=0, row=0, acc=0, busy=0, rd_req=0, rd_cand=0, rd_row=0, done=0, best_mvx=0, best_mvy=0, best_sad=0. No done pulse for the aborted search.

## Configuration
- FRAC_SEARCH_EARLY_TERM_EN defined: in FETCH, when a row is accepted with cand≠0 and the updated acc ≥ best_sad, the remaining rows of that candidate are skipped. The FSM goes straight to EVAL, which performs no update, so latency shrinks. The winner, and best_sad for the winner, are identical to the non-early-termination result.
- Not defined: every candidate always fetches all HEIGHT rows, and latency is fixed at 82 cycles with no stalls.

## Test plan
- Reset, then start, with rd_valid tied to 1 and row_sad=10 for all rows → 72 accepted requests in order (cand 0..8, row 0..7); done at cycle k+82; best_mvx=−1, best_mvy=−1, best_sad=80 (tie keeps c=0).
- row_sad=1 for cand 4 and 50 otherwise → best_mvx=0, best_mvy=0, best_sad=8.
- Random rd_valid stalls (about 50%) with cand 8 minimal → rd_cand and rd_row stable during stalls; best_mvx=+1, best_mvy=+1; done delayed by exactly the number of stall cycles.
- start pulsed during FETCH, and rd_valid pulsed in EVAL/IDLE → no effect; result and latency unchanged.
- reset asserted while cand=5 → all outputs zero next cycle, no done pulse; a following start runs a clean full search.
- FRAC_SEARCH_EARLY_TERM_EN with cand 0 SAD=8 and all others 255 per row → candidates 1..8 each fetch only 1 row; done at k+1+9+8×2 = k+26; best_sad=8.
